// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern-scan controller.
package seq_pkg;

  localparam int PAT_W     = 8;
  localparam int IDX_W     = $clog2(PAT_W);
  localparam int CNT_W_DEF = 8;
  localparam int NB_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_match.sv
// Overlapping bit-serial pattern matcher: sliding window plus fill count.
module seq_match
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  window;
  logic [FILL_W-1:0] fill;

  // The window only holds PAT_W-1 bits; the incoming bit completes the compare.
  assign match = en && (fill == FILL_FULL) && ({window, bit_in} == pattern);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      window <= '0;
      fill   <= '0;
    end else if (clr) begin
      window <= '0;
      fill   <= '0;
    end else if (en) begin
      window <= {window[PAT_W-3:0], bit_in};
      if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: accepts bytes over valid/ready, shifts them MSB-first
// through seq_match and counts hits per frame.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NB_W  = NB_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [NB_W-1:0]  nbytes,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] in_data,
  output logic             in_ready,
  output logic             bit_out,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  output logic [1:0]       cs
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on state, so the source may wait on it freely.

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] shreg;
  logic [NB_W-1:0]  nb_rem;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             hit_q;
  logic             done_q;
  logic             m_clr;
  logic             m_en;
  logic             match;

  assign m_clr    = (state == ST_IDLE) && start;
  assign m_en     = (state == ST_SHIFT);
  assign bit_out  = m_en & shreg[idx];
  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign cs       = state;
  assign hit      = hit_q;
  assign hit_cnt  = cnt;
  assign done     = done_q;

  seq_match u_match (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (m_clr),
    .en      (m_en),
    .bit_in  (bit_out),
    .pattern (pat_q),
    .match   (match)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      pat_q  <= '0;
      shreg  <= '0;
      nb_rem <= '0;
      idx    <= '0;
      cnt    <= '0;
      hit_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pat_q  <= pattern;
            nb_rem <= nbytes;
            cnt    <= '0;
            if (nbytes == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            shreg  <= in_data;
            idx    <= IDX_MAX;
            nb_rem <= nb_rem - NB_W'(1);
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // hit and the count land on the edge that consumes the completing bit
          if (match) begin
            hit_q <= 1'b1;
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end
          idx <= idx - IDX_W'(1);
          if (idx == '0) begin
            if (nb_rem != '0) begin
              state <= ST_LOAD;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller for the serial pattern-detection path. It accepts a frame of bytes over a valid/ready handshake and serializes each byte MSB-first, one bit per clock, into a programmable overlapping pattern matcher. It counts matches per frame and signals frame completion. It sits between a byte-wide source and the bit-serial sequence-detection logic, and sequences that logic frame by frame.

## Interface
- `PAT_W`, 8: pattern length in bits; fixed equal to byte width.
- `CNT_W`, 8: width of the saturating hit counter.
- `NB_W`, 4: width of the frame-length field.

Ports:
- `clk` in 1: the single clock, rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `start` in 1: frame request; sampled only in IDLE.
- `pattern` in 8: match pattern, MSB is the first bit; latched when `start` is accepted.
- `nbytes` in `NB_W`: frame length in bytes; latched when `start` is accepted.
- `in_valid` in 1: source byte valid.
- `in_data` in 8: source byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `bit_out` out 1: bit currently being shifted; 0 outside SHIFT.
- `busy` out 1: high in any state other than IDLE.
- `hit` out 1: one-cycle pulse per match.
- `hit_cnt` out `CNT_W`: matches in the current or last frame; saturating.
- `done` out 1: one-cycle pulse at frame end.
- `cs` out 2: current state, for debug.

## Operation
- States: IDLE=0, LOAD=1, SHIFT=2, DONE=3.
- **IDLE**
  - If `start` is high: latch `pattern` and `nbytes`, clear `hit_cnt`, clear the match window.
  - Then go to LOAD, or to DONE if `nbytes==0`.
  - `start` in any other state is ignored.
- **LOAD**
  - `in_ready=1`.
  - On handshake: load the shift byte, set bit index to 7, decrement bytes-remaining, go to SHIFT.
  - Otherwise hold, with no timeout.
- **SHIFT**
  - `bit_out = byte[idx]`; the matcher consumes `bit_out` every cycle.
  - `idx` decrements each cycle.
  - After `idx==0`: go to LOAD if bytes remain, else DONE.
- **DONE**: `done=1` for one cycle, then IDLE.
- **Matcher**
  - Holds the last `PAT_W-1` bits plus a fill count saturating at `PAT_W-1`.
  - Match when fill is full and `{window, bit_out} == pattern`.
  - Overlapping matches count.
  - The window persists across bytes within a frame; it is cleared only at frame start, so no match can span two frames.
- **Counter**
  - `hit` and the `hit_cnt` increment are registered on the edge that consumes the completing bit.
  - `hit_cnt` saturates at `2^CNT_W-1`.
  - `hit_cnt` holds its value after DONE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `in_ready=0`, `busy=0`, `hit=0`, `hit_cnt=0`, `done=0`, `bit_out=0`, `cs=0`. Window and fill are cleared.
- Each byte costs 1 LOAD cycle (with `in_valid` already high) plus 8 SHIFT cycles.
- N-byte frame with `in_valid` held high:
  - The start edge is edge 0.
  - `done` is high in the cycle following edge 9·N.
  - Each LOAD cycle spent waiting with `in_valid` low adds one cycle.
- A match completed by the last bit of the frame raises `hit` in the same cycle as `done`. `hit_cnt` is final in that cycle.
- `in_ready` is a pure function of state and never depends on `in_valid`.
- `rstn` low in any state, including mid-SHIFT, immediately forces all reset values. The partial frame is discarded and no `done` is produced.

## Structure
- Package `seq_pkg`:
  - state enum (2-bit) with the encodings above;
  - `PAT_W` constant;
  - `CNT_W` and `NB_W` defaults.
- Sub-module `seq_match`:
  - inputs: `clk`, `rstn`, `clr`, `en`, `bit_in`, `pattern`;
  - output: combinational `match`;
  - contents: window shift register and fill counter.
- The top level holds the FSM, byte shifter, bytes-remaining counter, and hit register/counter.

## Test plan
- **Single exact match**: `pattern=0xAB`, `nbytes=1`, byte `0xAB` → one `hit` pulse coincident with `done`, `hit_cnt=1`, `done` 9 cycles after the start edge.
- **Overlap**: `pattern=0xAA`, `nbytes=2`, bytes `0xAA,0xAA` → 5 hits (stream positions 8, 10, 12, 14, 16), `hit_cnt=5`, `done` at edge 18.
- **Frame isolation**: frame 1 is `0x0A` with `pattern=0xAB`; frame 2 is `0xB0` → 0 hits in both frames. The cross-frame bit sequence must not match.
- **Backpressure**: `nbytes=2`, `in_valid` low for 3 cycles in the second LOAD → `done` at edge 21, and `in_ready` stays high throughout the wait.
- **Edge cases**:
  - `nbytes=0` → `done` in the cycle after the start edge, `hit_cnt=0`, `in_ready` never high.
  - `CNT_W=2` with `pattern=0x00` and bytes `0x00,0x00` → `hit_cnt` saturates at 3.
- **Reset mid-operation**: assert `rstn` low during SHIFT with `idx=4` → all outputs at reset values, no `done`. A following `start` runs a clean frame.
